// File: rtl/pattern_counter.sv
// Pattern counter: tracks a configurable symbol sequence (with optional
// per-symbol repeats) and counts completed matches with saturation.
module pattern_counter #(
  parameter int SYM_W = 2,
  parameter int DEPTH = 3,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sym_valid,
  input  logic [SYM_W-1:0]         sym,
  input  logic                     cfg_load,
  input  logic [DEPTH*SYM_W-1:0]   cfg_pat,
  input  logic [$clog2(DEPTH+1)-1:0] cfg_len,
  input  logic                     cfg_rpt,
  input  logic                     cnt_clr,
  output logic                     match,
  output logic                     hit,
  output logic [CNT_W-1:0]         hit_cnt
);

  localparam int LW = $clog2(DEPTH+1);

  logic [DEPTH*SYM_W-1:0] pat_q;
  logic [LW-1:0]          len_q;
  logic [LW-1:0]          k_q;
  logic [LW-1:0]          k_nxt;
  logic                   rpt_q;
  logic                   hit_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [SYM_W-1:0]       pat_k;
  logic [SYM_W-1:0]       pat_km1;
  logic                   ra;
  logic                   rb;
  logic                   rc;
  logic                   cfg_ok;
  logic                   step_hit;

  // Mux pat[k] and pat[k-1] without ever indexing past the table.
  always_comb begin
    pat_k   = '0;
    pat_km1 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (k_q == LW'(i))
        pat_k = pat_q[i*SYM_W +: SYM_W];
      if (k_q == LW'(i+1))
        pat_km1 = pat_q[i*SYM_W +: SYM_W];
    end
  end

  always_comb begin
    ra = (k_q < len_q) && (sym == pat_k);
    rb = !ra && rpt_q && (k_q != '0)
         && (sym == pat_km1);
    rc = !ra && !rb
         && (sym == pat_q[SYM_W-1:0]);
    k_nxt = '0;
    unique case (1'b1)
      ra:      k_nxt = k_q + 1'b1;
      rb:      k_nxt = k_q;
      rc:      k_nxt = LW'(1);
      default: k_nxt = '0;
    endcase
  end

  assign cfg_ok   = (cfg_len != '0)
                 && (cfg_len <= LW'(DEPTH));
  assign step_hit = sym_valid && !cfg_load
                 && ra && (k_nxt == len_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q   <= '0;
      hit_q <= 1'b0;
      cnt_q <= '0;
      len_q <= LW'(DEPTH);
      rpt_q <= 1'b1;
      for (int i = 0; i < DEPTH; i++)
        pat_q[i*SYM_W +: SYM_W] <= SYM_W'(i+1);
    end else begin
      hit_q <= step_hit;
      if (cfg_load) begin
        k_q <= '0;
        if (cfg_ok) begin
          pat_q <= cfg_pat;
          len_q <= cfg_len;
          rpt_q <= cfg_rpt;
        end
      end else if (sym_valid) begin
        k_q <= k_nxt;
      end
      if (cnt_clr)
        cnt_q <= '0;
      else if (step_hit && (cnt_q != '1))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign match   = (k_q == len_q);
  assign hit     = hit_q;
  assign hit_cnt = cnt_q;

endmodule

// File: tb/tb_pattern_counter.sv
// Scoreboard bench for pattern_counter: directed vectors push expected
// {match,hit,hit_cnt}; a monitor pops and compares after each edge.
module tb_pattern_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sym_valid = 1'b0;
  logic [1:0] sym = '0;
  logic       cfg_load = 1'b0;
  logic [5:0] cfg_pat = '0;
  logic [1:0] cfg_len = '0;
  logic       cfg_rpt = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       match;
  logic       hit;
  logic [7:0] hit_cnt;

  logic [9:0] exp_q[$];
  string      tag_q[$];
  string      phase = "init";
  int         n_vec = 0;
  int         n_mis = 0;

  pattern_counter #(
    .SYM_W(2), .DEPTH(3), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .sym_valid(sym_valid), .sym(sym),
    .cfg_load(cfg_load), .cfg_pat(cfg_pat),
    .cfg_len(cfg_len), .cfg_rpt(cfg_rpt),
    .cnt_clr(cnt_clr), .match(match),
    .hit(hit), .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

  task automatic drive(
    input logic r, input logic v,
    input logic [1:0] s, input logic ld,
    input logic [5:0] p, input logic [1:0] l,
    input logic rp, input logic c,
    input logic em, input logic eh,
    input logic [7:0] ec);
    @(negedge clk);
    rst_n = r; sym_valid = v; sym = s;
    cfg_load = ld; cfg_pat = p;
    cfg_len = l; cfg_rpt = rp; cnt_clr = c;
    exp_q.push_back({em, eh, ec});
    tag_q.push_back(phase);
  endtask

  task automatic sv(input logic [1:0] s,
    input logic em, input logic eh,
    input logic [7:0] ec);
    drive(1, 1, s, 0, 6'd0, 2'd0, 0, 0,
          em, eh, ec);
  endtask

  task automatic idle(input logic em,
    input logic eh, input logic [7:0] ec);
    drive(1, 0, 2'd0, 0, 6'd0, 2'd0, 0, 0,
          em, eh, ec);
  endtask

  task automatic rst();
    drive(0, 0, 2'd0, 0, 6'd0, 2'd0, 0, 0,
          0, 0, 8'd0);
  endtask

  task automatic ld(input logic v,
    input logic [1:0] s, input logic [5:0] p,
    input logic [1:0] l, input logic rp,
    input logic [7:0] ec);
    drive(1, v, s, 1, p, l, rp, 0,
          0, 0, ec);
  endtask

  always begin
    logic [9:0] e;
    logic [9:0] a;
    string t;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {match, hit, hit_cnt};
      n_vec++;
      if (a !== e) begin
        n_mis++;
        $display("FAIL %s vec %0d: got m=%0b h=%0b cnt=%0d, want m=%0b h=%0b cnt=%0d",
          t, n_vec, a[9], a[8], a[7:0],
          e[9], e[8], e[7:0]);
      end
    end
  end

  initial begin
    int c;
    phase = "reset";
    rst(); rst();

    phase = "rpt_run";
    sv(1, 0, 0, 0); sv(1, 0, 0, 0);
    sv(2, 0, 0, 0); sv(2, 0, 0, 0);
    sv(3, 1, 1, 1); sv(3, 1, 0, 1);
    idle(1, 0, 1); idle(1, 0, 1);

    phase = "twice";
    rst();
    sv(1, 0, 0, 0); sv(2, 0, 0, 0);
    sv(3, 1, 1, 1); sv(1, 0, 0, 1);
    idle(0, 0, 1);
    sv(2, 0, 0, 1); sv(3, 1, 1, 2);

    phase = "break13";
    sv(1, 0, 0, 2); sv(3, 0, 0, 2);
    sv(2, 0, 0, 2); sv(3, 0, 0, 2);
    phase = "break120";
    sv(1, 0, 0, 2); sv(2, 0, 0, 2);
    sv(0, 0, 0, 2); sv(3, 0, 0, 2);

    phase = "pat221";
    ld(1, 2, 6'b011010, 3, 1, 2);
    sv(2, 0, 0, 2); sv(2, 0, 0, 2);
    sv(2, 0, 0, 2); sv(1, 1, 1, 3);

    phase = "load_discard";
    ld(1, 1, 6'b111001, 3, 0, 3);
    sv(2, 0, 0, 3); sv(3, 0, 0, 3);

    phase = "strict";
    sv(1, 0, 0, 3); sv(1, 0, 0, 3);
    sv(2, 0, 0, 3); sv(3, 1, 1, 4);
    sv(3, 0, 0, 4);
    sv(1, 0, 0, 4); sv(2, 0, 0, 4);
    sv(2, 0, 0, 4); sv(3, 0, 0, 4);

    phase = "len2_tail";
    ld(0, 0, 6'b001001, 2, 0, 4);
    sv(1, 0, 0, 4); sv(2, 1, 1, 5);
    sv(0, 0, 0, 5);

    phase = "sym_zero";
    ld(0, 0, 6'b001100, 2, 1, 5);
    sv(0, 0, 0, 5); sv(0, 0, 0, 5);
    sv(3, 1, 1, 6);

    phase = "len1";
    ld(0, 0, 6'b000010, 1, 1, 6);
    sv(2, 1, 1, 7); sv(2, 1, 0, 7);
    sv(1, 0, 0, 7);

    phase = "bad_len";
    ld(0, 0, 6'b000000, 0, 0, 7);
    sv(2, 1, 1, 8);

    phase = "mid_reset";
    rst();
    sv(1, 0, 0, 0); sv(2, 0, 0, 0);
    drive(0, 1, 2'd3, 1, 6'b111111, 2'd1,
          0, 1, 0, 0, 8'd0);
    sv(3, 0, 0, 0);
    sv(1, 0, 0, 0); sv(2, 0, 0, 0);
    sv(3, 1, 1, 1);

    phase = "clr";
    drive(1, 0, 2'd0, 0, 6'd0, 2'd0,
          0, 1, 1, 0, 8'd0);

    phase = "saturate";
    c = 0;
    for (int i = 0; i < 256; i++) begin
      sv(1, 0, 0, 8'(c));
      sv(2, 0, 0, 8'(c));
      c = (c + 1 > 255) ? 255 : c + 1;
      sv(3, 1, 1, 8'(c));
    end

    phase = "clr_on_hit";
    sv(1, 0, 0, 255); sv(2, 0, 0, 255);
    drive(1, 1, 2'd3, 0, 6'd0, 2'd0,
          0, 1, 1, 1, 8'd0);
    idle(1, 0, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++)
      @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_mis++;
      $display("FAIL drain: got %0d pending, want 0",
        exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
      n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/pattern_counter.md
PATTERN_COUNTER -- requirements
Module: pattern_counter

Interface
REQ-001 SHALL have parameter SYM_W, default 2, symbol width in bits.
REQ-002 SHALL have parameter DEPTH, default 3, maximum pattern length in symbols; legal range 2..16.
REQ-003 SHALL have parameter CNT_W, default 8, width of the hit counter.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port sym_valid  input  1  sym is presented this cycle.
REQ-007 SHALL have port sym  input  SYM_W  incoming symbol.
REQ-008 SHALL have port cfg_load  input  1  latch new configuration this cycle.
REQ-009 SHALL have port cfg_pat  input  DEPTH*SYM_W  pattern; symbol i at bits [i*SYM_W +: SYM_W].
REQ-010 SHALL have port cfg_len  input  $clog2(DEPTH+1)  pattern length.
REQ-011 SHALL have port cfg_rpt  input  1  1 = each pattern symbol may repeat; 0 = strict sequence.
REQ-012 SHALL have port cnt_clr  input  1  clear the hit counter.
REQ-013 SHALL have port match  output  1  high while the full pattern is currently matched.
REQ-014 SHALL have port hit  output  1  one-cycle pulse on each completed match.
REQ-015 SHALL have port hit_cnt  output  CNT_W  saturating count of hits.

Function
REQ-016 SHALL hold a stage register k in 0..len; k=0 means nothing matched, k=j means pattern symbols 0..j-1 matched, current run on pat[j-1].
REQ-017 SHALL leave k, hit_cnt unchanged on any edge with sym_valid=0 and no cfg_load/cnt_clr; hit SHALL be 0 the following cycle.
REQ-018 SHALL, on an edge with sym_valid=1, update k by first-true rule: (a) k<len and sym==pat[k] -> k+1; (b) cfg_rpt=1, k>=1 and sym==pat[k-1] -> k; (c) sym==pat[0] -> 1; (d) else -> 0.
REQ-019 SHALL drive match = (k==len) combinationally from the stage register.
REQ-020 SHALL assert hit for exactly the one cycle after an edge where k went from len-1 to len; staying at len or re-entering via rule (b) SHALL NOT pulse hit.
REQ-021 SHALL increment hit_cnt on the same edge that sets hit, saturating at 2^CNT_W-1.
REQ-022 SHALL, on cnt_clr=1, set hit_cnt to 0; cnt_clr SHALL win over a simultaneous increment (result 0); hit pulse is unaffected.
REQ-023 SHALL, on cfg_load=1 with 1<=cfg_len<=DEPTH, latch cfg_pat, cfg_len, cfg_rpt and force k=0; a simultaneous sym_valid symbol SHALL be discarded.
REQ-024 SHALL ignore cfg_load with cfg_len=0 or cfg_len>DEPTH: configuration unchanged, but k still forced to 0.
REQ-025 SHALL use only the first len pattern symbols; symbols at index >= len SHALL have no effect.
REQ-026 SHALL treat every symbol value, including 0, as an ordinary comparable symbol.

Reset
REQ-027 SHALL, on an edge with rst_n=0, set k=0, hit=0, hit_cnt=0, len=DEPTH, cfg_rpt=1, pat[i]=(i+1) mod 2^SYM_W; rst_n SHALL override cfg_load, cnt_clr and sym_valid.
REQ-028 SHALL present match=0, hit=0, hit_cnt=0 in the cycle following a reset edge, including reset applied mid-pattern.

Verification (defaults SYM_W=2, DEPTH=3, CNT_W=8, reset config 1,2,3, rpt=1)
REQ-029 SHALL cover: syms 1,1,2,2,3,3 -> match rises after 5th symbol, stays high through 6th; hit one cycle; hit_cnt=1.
REQ-030 SHALL cover: 1,2,3,1,2,3 -> match drops after 4th (k=1), second hit after 6th, hit_cnt=2; 1,3 -> k=0; 1,2,0 -> k=0; gaps with sym_valid=0 change nothing.
REQ-031 SHALL cover: load pat 2,2,1 len 3 rpt 1; syms 2,2,2,1 -> k=1,2,2,3, one hit.
REQ-032 SHALL cover: load pat 1,2,3 rpt 0; syms 1,1,2,3 -> k=1,1,2,3, hit; then 3 -> k=0; 1,2,2 -> k=0.
REQ-033 SHALL cover: 256 complete matches -> hit_cnt=255 (saturated); cnt_clr coincident with a hit -> hit_cnt=0, hit still pulses.
REQ-034 SHALL cover: rst_n=0 at k=2 -> k=0, hit_cnt=0, config back to 1,2,3; cfg_load with cfg_len=0 -> config unchanged, k=0.
